// File: rtl/fp_mult_pkg.sv
// rtl/fp_mult_pkg.sv - shared types, flag indices and format helpers for fp_mult_param
package fp_mult_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_UNPACK = 3'd1,
      ST_MULT   = 3'd2,
      ST_NORM   = 3'd3,
      ST_ROUND  = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      RND_RNE = 2'd0,
      RND_RTZ = 2'd1,
      RND_RUP = 2'd2,
      RND_RDN = 2'd3
   } rnd_t;

   localparam int FLAG_NV = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   function automatic int bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Returned wide so any format fits; callers keep the low 1+exp_w+man_w bits.
   function automatic logic [255:0] qnan(input int exp_w, input int man_w);
      logic [255:0] r;
      r = ((256'd1 << exp_w) - 256'd1) << man_w;
      r = r | (256'd1 << (man_w - 1));
      return r;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter; all-zero input yields WIDTH
module fp_lzc #(
   parameter int WIDTH = 47,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic [WIDTH-1:0] data,
   output logic [CNT_W-1:0] count
);

   // Ascending scan: the highest set bit is the last to write the count.
   always_comb begin
      count = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (data[i]) count = CNT_W'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/fp_mult_param.sv
// rtl/fp_mult_param.sv - parametrised floating-point multiplier, fixed 4-edge latency,
// four rounding modes, flush-to-zero on underflow, result held under backpressure
module fp_mult_param
   import fp_mult_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [EXP_W+MAN_W:0]   a_i,
   input  logic [EXP_W+MAN_W:0]   b_i,
   input  logic [1:0]             rnd_i,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic [EXP_W+MAN_W:0]   product_o,
   output logic [3:0]             flags_o
);

   localparam int W     = 1 + EXP_W + MAN_W;
   localparam int PW    = 2 * (MAN_W + 1);
   localparam int SW    = EXP_W + 2;
   localparam int LZ_W  = $clog2(PW - 1) + 1;
   localparam int XW    = ((SW > LZ_W) ? SW : LZ_W) + 2;
   localparam int BIAS_I = bias(EXP_W);

   localparam logic [255:0]         QNAN_WIDE = qnan(EXP_W, MAN_W);
   localparam logic [W-1:0]         QNAN      = QNAN_WIDE[W-1:0];
   localparam logic signed [SW-1:0] BIAS_S    = SW'(BIAS_I);
   localparam logic signed [XW-1:0] EXP_ONE   = XW'(1);
   localparam logic signed [XW-1:0] EXP_OVF   = XW'((1 << EXP_W) - 1);

   state_t                 state;
   logic [W-1:0]           a_q, b_q;
   rnd_t                   rnd_q;
   logic                   sign_q;
   logic                   special_q;
   logic [W-1:0]           spec_res_q;
   logic                   spec_nv_q;
   logic [MAN_W:0]         ma_q, mb_q;
   logic signed [SW-1:0]   ea_q, eb_q;
   logic [PW-1:0]          prod_q;
   logic signed [SW-1:0]   esum_q;
   logic [MAN_W:0]         mant_q;
   logic                   guard_q, sticky_q;
   logic signed [XW-1:0]   exp_q;
   logic [W-1:0]           product_q;
   logic [3:0]             flags_q;

   // Operand classification
   logic [EXP_W-1:0] a_exp, b_exp;
   logic [MAN_W-1:0] a_man, b_man;
   logic a_nan, a_inf, a_zero, a_snan;
   logic b_nan, b_inf, b_zero, b_snan;
   logic sign_u;

   assign a_exp  = a_q[W-2:MAN_W];
   assign b_exp  = b_q[W-2:MAN_W];
   assign a_man  = a_q[MAN_W-1:0];
   assign b_man  = b_q[MAN_W-1:0];
   assign a_nan  = (&a_exp) && (|a_man);
   assign b_nan  = (&b_exp) && (|b_man);
   assign a_inf  = (&a_exp) && !(|a_man);
   assign b_inf  = (&b_exp) && !(|b_man);
   assign a_zero = !(|a_exp) && !(|a_man);
   assign b_zero = !(|b_exp) && !(|b_man);
   assign a_snan = a_nan && !a_man[MAN_W-1];
   assign b_snan = b_nan && !b_man[MAN_W-1];
   assign sign_u = a_q[W-1] ^ b_q[W-1];

   logic         spec_hit;
   logic         spec_nv;
   logic [W-1:0] spec_res;

   always_comb begin
      spec_hit = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
      spec_nv  = 1'b0;
      spec_res = {sign_u, {(W-1){1'b0}}};
      if (a_nan || b_nan) begin
         spec_res = QNAN;
         spec_nv  = a_snan || b_snan;
      end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
         spec_res = QNAN;
         spec_nv  = 1'b1;
      end else if (a_inf || b_inf) begin
         spec_res = {sign_u, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
   end

   // Normalisation: leading 1 ends up at bit 2*MAN_W of the product
   logic [LZ_W-1:0]      lz;
   logic [PW-2:0]        shifted;
   logic                 extra;
   logic signed [XW-1:0] esum_x;
   logic signed [XW-1:0] exp_n;

   fp_lzc #(.WIDTH(PW - 1), .CNT_W(LZ_W)) u_lzc (
      .data  (prod_q[PW-2:0]),
      .count (lz)
   );

   assign esum_x = {{(XW-SW){esum_q[SW-1]}}, esum_q};

   always_comb begin
      shifted = prod_q[PW-2:0];
      extra   = 1'b0;
      exp_n   = esum_x;
      if (prod_q[PW-1]) begin
         shifted = prod_q[PW-1:1];
         extra   = prod_q[0];
         exp_n   = esum_x + XW'(1);
      end else begin
         shifted = prod_q[PW-2:0] << lz;
         exp_n   = esum_x - XW'(lz);
      end
   end

   // Rounding and range checks
   logic                 inc;
   logic [MAN_W+1:0]     rounded;
   logic [MAN_W-1:0]     frac_r;
   logic signed [XW-1:0] exp_r;
   logic [W-1:0]         round_res;
   logic [3:0]           round_flags;
   logic [W-1:0]         inf_res, max_res;

   assign inf_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
   assign max_res = {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

   always_comb begin
      case (rnd_q)
         RND_RNE: inc = guard_q && (sticky_q || mant_q[0]);
         RND_RUP: inc = (guard_q || sticky_q) && !sign_q;
         RND_RDN: inc = (guard_q || sticky_q) && sign_q;
         default: inc = 1'b0;
      endcase
      rounded = {1'b0, mant_q} + {{(MAN_W+1){1'b0}}, inc};
      if (rounded[MAN_W+1]) begin
         frac_r = rounded[MAN_W:1];
         exp_r  = exp_q + XW'(1);
      end else begin
         frac_r = rounded[MAN_W-1:0];
         exp_r  = exp_q;
      end

      round_flags = 4'b0000;
      round_res   = {sign_q, exp_r[EXP_W-1:0], frac_r};
      if (exp_q < EXP_ONE) begin
         round_res            = {sign_q, {(W-1){1'b0}}};
         round_flags[FLAG_UF] = 1'b1;
         round_flags[FLAG_NX] = 1'b1;
      end else if (exp_r >= EXP_OVF) begin
         round_flags[FLAG_OF] = 1'b1;
         round_flags[FLAG_NX] = 1'b1;
         case (rnd_q)
            RND_RNE: round_res = inf_res;
            RND_RTZ: round_res = max_res;
            RND_RUP: round_res = sign_q ? max_res : inf_res;
            default: round_res = sign_q ? inf_res : max_res;
         endcase
      end else begin
         round_flags[FLAG_NX] = guard_q || sticky_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         rnd_q      <= RND_RNE;
         sign_q     <= 1'b0;
         special_q  <= 1'b0;
         spec_res_q <= '0;
         spec_nv_q  <= 1'b0;
         ma_q       <= '0;
         mb_q       <= '0;
         ea_q       <= '0;
         eb_q       <= '0;
         prod_q     <= '0;
         esum_q     <= '0;
         mant_q     <= '0;
         guard_q    <= 1'b0;
         sticky_q   <= 1'b0;
         exp_q      <= '0;
         product_q  <= '0;
         flags_q    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (valid_i) begin
                  a_q   <= a_i;
                  b_q   <= b_i;
                  rnd_q <= rnd_t'(rnd_i);
                  state <= ST_UNPACK;
               end
            end
            ST_UNPACK: begin
               sign_q     <= sign_u;
               special_q  <= spec_hit;
               spec_res_q <= spec_res;
               spec_nv_q  <= spec_nv;
               // Subnormals: hidden bit 0, effective exponent 1
               ma_q       <= {|a_exp, a_man};
               mb_q       <= {|b_exp, b_man};
               ea_q       <= (|a_exp) ? {2'b00, a_exp} : {{(SW-1){1'b0}}, 1'b1};
               eb_q       <= (|b_exp) ? {2'b00, b_exp} : {{(SW-1){1'b0}}, 1'b1};
               state      <= ST_MULT;
            end
            ST_MULT: begin
               prod_q <= PW'(ma_q) * PW'(mb_q);
               esum_q <= ea_q + eb_q - BIAS_S;
               state  <= ST_NORM;
            end
            ST_NORM: begin
               mant_q   <= shifted[PW-2:MAN_W];
               guard_q  <= shifted[MAN_W-1];
               sticky_q <= (|shifted[MAN_W-2:0]) || extra;
               exp_q    <= exp_n;
               state    <= ST_ROUND;
            end
            ST_ROUND: begin
               product_q <= special_q ? spec_res_q : round_res;
               flags_q   <= special_q ? {spec_nv_q, 3'b000} : round_flags;
               state     <= ST_DONE;
            end
            ST_DONE: begin
               if (ready_i) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign ready_o   = (state == ST_IDLE);
   assign valid_o   = (state == ST_DONE);
   assign product_o = product_q;
   assign flags_o   = valid_o ? flags_q : 4'b0000;

endmodule

// File: tb/tb_fp_mult_param.sv
// tb/tb_fp_mult_param.sv - directed and randomized checks of fp_mult_param (binary32)
module tb_fp_mult_param;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic [1:0]  rnd_i = '0;
   logic        valid_o;
   logic        ready_i = 1'b1;
   logic [31:0] product_o;
   logic [3:0]  flags_o;

   int checks = 0;
   int errors = 0;

   fp_mult_param #(.EXP_W(8), .MAN_W(23)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .a_i       (a_i),
      .b_i       (b_i),
      .rnd_i     (rnd_i),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .product_o (product_o),
      .flags_o   (flags_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer product, rounded by comparing the discarded remainder with half an ulp.
   function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rnd,
                                   output logic [31:0] res, output logic [3:0] fl);
      logic sa, sb, s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inexact, up;
      logic [7:0]  ea, eb;
      logic [22:0] fa, fb;
      logic [23:0] ma, mb;
      longint unsigned p, keep, rem, half2;
      int k, be, xa, xb;
      sa = a[31]; ea = a[30:23]; fa = a[22:0];
      sb = b[31]; eb = b[30:23]; fb = b[22:0];
      s = sa ^ sb;
      a_nan = (ea == 8'hFF) && (fa != 0);  b_nan = (eb == 8'hFF) && (fb != 0);
      a_inf = (ea == 8'hFF) && (fa == 0);  b_inf = (eb == 8'hFF) && (fb == 0);
      a_zero = (ea == 0) && (fa == 0);     b_zero = (eb == 0) && (fb == 0);
      fl = 4'b0000;
      if (a_nan || b_nan) begin
         res = 32'h7FC00000;
         fl[3] = (a_nan && !fa[22]) || (b_nan && !fb[22]);
         return;
      end
      if ((a_inf && b_zero) || (a_zero && b_inf)) begin
         res = 32'h7FC00000; fl = 4'b1000; return;
      end
      if (a_inf || b_inf) begin res = {s, 8'hFF, 23'h0}; return; end
      if (a_zero || b_zero) begin res = {s, 31'h0}; return; end
      ma = (ea == 0) ? {1'b0, fa} : {1'b1, fa};
      mb = (eb == 0) ? {1'b0, fb} : {1'b1, fb};
      xa = (ea == 0) ? 1 : int'(ea);
      xb = (eb == 0) ? 1 : int'(eb);
      p = {40'b0, ma} * {40'b0, mb};
      k = 0;
      for (int i = 0; i < 48; i++) if (p[i]) k = i;
      be = k + xa + xb - 127 - 46;
      if (be < 1) begin res = {s, 31'h0}; fl = 4'b0011; return; end
      if (k >= 23) begin
         keep  = p >> (k - 23);
         rem   = p - (keep << (k - 23));
         half2 = 64'd1 << (k - 23);
      end else begin
         keep = p << (23 - k); rem = 0; half2 = 1;
      end
      inexact = (rem != 0);
      case (rnd)
         2'd0: up = ((rem << 1) > half2) || (((rem << 1) == half2) && keep[0]);
         2'd1: up = 1'b0;
         2'd2: up = inexact && !s;
         default: up = inexact && s;
      endcase
      keep = keep + {63'b0, up};
      if (keep == (64'd1 << 24)) begin keep = keep >> 1; be++; end
      if (be >= 255) begin
         fl = 4'b0101;
         case (rnd)
            2'd0: res = {s, 8'hFF, 23'h0};
            2'd1: res = {s, 8'hFE, 23'h7FFFFF};
            2'd2: res = s ? {s, 8'hFE, 23'h7FFFFF} : {s, 8'hFF, 23'h0};
            default: res = s ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF};
         endcase
         return;
      end
      res = {s, be[7:0], keep[22:0]};
      fl  = {3'b000, inexact};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 11))
         0: v[30:0] = '0;
         1: v[30:23] = 8'h00;
         2: v[30:0] = {8'hFF, 23'h0};
         3: begin v[30:23] = 8'hFF; if (v[22:0] == 0) v[0] = 1'b1; end
         4: v[30:23] = 8'($urandom_range(200, 254));
         5: v[30:23] = 8'($urandom_range(1, 60));
         6: v[22:0] = 23'h7FFFFF;
         default: v[30:23] = 8'($urandom_range(1, 254));
      endcase
      return v;
   endfunction

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rnd);
      @(negedge clk);
      a_i = a; b_i = b; rnd_i = rnd; valid_i = 1'b1;
      check("ready_at_accept", {63'b0, ready_o}, 64'd1);
      @(posedge clk); #1;
      valid_i = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (!valid_o && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] rnd, input logic [31:0] er, input logic [3:0] ef);
      int lat;
      issue(a, b, rnd);
      wait_result(lat);
      check({tag, "_latency"}, 64'(lat), 64'd4);
      check({tag, "_product"}, {32'b0, product_o}, {32'b0, er});
      check({tag, "_flags"}, {60'b0, flags_o}, {60'b0, ef});
      @(posedge clk); #1;
      check({tag, "_released"}, {62'b0, valid_o, ready_o}, 64'd1);
   endtask

   initial begin
      logic [31:0] a, b, er, hold_p;
      logic [3:0]  ef, hold_f;
      logic [1:0]  r;
      int lat;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", {63'b0, ready_o}, 64'd1);
      check("reset_valid", {63'b0, valid_o}, 64'd0);
      check("reset_product", {32'b0, product_o}, 64'd0);
      check("reset_flags", {60'b0, flags_o}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("mul_7p5",    32'h40400000, 32'h40200000, 2'd0, 32'h40F00000, 4'b0000);
      run_op("inf_x_zero", 32'h7F800000, 32'h00000000, 2'd0, 32'h7FC00000, 4'b1000);
      run_op("ninf_x_two", 32'hFF800000, 32'h40000000, 2'd0, 32'hFF800000, 4'b0000);
      run_op("ovf_rne",    32'h7F7FFFFF, 32'h40000000, 2'd0, 32'h7F800000, 4'b0101);
      run_op("ovf_rtz",    32'h7F7FFFFF, 32'h40000000, 2'd1, 32'h7F7FFFFF, 4'b0101);
      run_op("rnd_rne",    32'h3F800001, 32'h3F800001, 2'd0, 32'h3F800002, 4'b0001);
      run_op("rnd_rup",    32'h3F800001, 32'h3F800001, 2'd2, 32'h3F800003, 4'b0001);
      run_op("subnorm_in", 32'h00400000, 32'h4B000000, 2'd0, 32'h0B800000, 4'b0000);
      run_op("underflow",  32'h00800000, 32'h80800000, 2'd0, 32'h80000000, 4'b0011);
      run_op("snan",       32'h7F800001, 32'h3F800000, 2'd0, 32'h7FC00000, 4'b1000);
      run_op("qnan",       32'hFFC00001, 32'h3F800000, 2'd3, 32'h7FC00000, 4'b0000);

      // Backpressure: result must hold and new operands must be ignored
      a = 32'h40490FDB; b = 32'hC02DF854; r = 2'd3;
      ref_mul(a, b, r, hold_p, hold_f);
      ready_i = 1'b0;
      issue(a, b, r);
      wait_result(lat);
      check("bp_latency", 64'(lat), 64'd4);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         valid_i = (i % 2 == 0);
         a_i = $urandom; b_i = $urandom;
         check("bp_ready_low", {63'b0, ready_o}, 64'd0);
         check("bp_valid_held", {63'b0, valid_o}, 64'd1);
         check("bp_product", {32'b0, product_o}, {32'b0, hold_p});
         check("bp_flags", {60'b0, flags_o}, {60'b0, hold_f});
      end
      @(negedge clk);
      valid_i = 1'b0;
      ready_i = 1'b1;
      @(posedge clk); #1;
      check("bp_handshake", {62'b0, valid_o, ready_o}, 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_no_extra", {62'b0, valid_o, ready_o}, 64'd1);
      end

      // Reset while the operation sits in MULT
      issue(32'h40400000, 32'h40200000, 2'd0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_ready", {63'b0, ready_o}, 64'd1);
      check("rst_mid_valid", {63'b0, valid_o}, 64'd0);
      check("rst_mid_product", {32'b0, product_o}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check("rst_no_result", {63'b0, valid_o}, 64'd0);
      end
      run_op("after_reset", 32'hC1200000, 32'h3E800000, 2'd0, 32'hC0200000, 4'b0000);

      for (int n = 0; n < 150; n++) begin
         a = rand_op();
         b = rand_op();
         r = 2'($urandom_range(0, 3));
         ref_mul(a, b, r, er, ef);
         run_op($sformatf("rand%0d_%h_%h_r%0d", n, a, b, r), a, b, r, er, ef);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
